// File: rtl/inst_sram_if.sv
// Instruction-fetch bus between the fetch stage (master) and the instruction
// memory responder (slave).
interface inst_sram_if;
  // Handshake: a request transfers in any cycle where req & addr_ok are both
  // high; addr must be stable while req is high. data_ok is a one-cycle pulse
  // qualifying rdata/rdata_err, and responses return in request order.
  logic        req;
  logic [31:0] addr;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        rdata_err;

  modport master (
    output req, addr,
    input  addr_ok, data_ok, rdata, rdata_err
  );

  modport slave (
    input  req, addr,
    output addr_ok, data_ok, rdata, rdata_err
  );
endinterface

// File: rtl/inst_sram_responder.sv
// Instruction memory responder: in-order queue of outstanding fetches, each
// answered from a preloadable word array after a programmable latency.
module inst_sram_responder #(
  parameter int          ADDR_W  = 12,
  parameter logic [31:0] BASE    = 32'h1c000000,
  parameter int          DEPTH   = 2,
  parameter int          LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  inst_sram_if.slave        bus,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_idx,
  input  logic [31:0]       ld_data
);

  if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
    $error("inst_sram_responder: DEPTH must be in 1..4");
  end
  if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
    $error("inst_sram_responder: LATENCY must be in 1..8");
  end

  localparam int         PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] LAT    = 4'(LATENCY);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  logic [31:0] mem [0:(1 << ADDR_W) - 1];

  logic [ADDR_W-1:0] q_idx [DEPTH];
  logic              q_err [DEPTH];
  logic [3:0]        q_age [DEPTH];
  logic [DEPTH-1:0]  q_vld;
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [2:0]        count;

  logic [31:0]       off;
  logic              req_err;
  logic [ADDR_W-1:0] req_idx;
  logic              push;
  logic              head_rdy;
  logic              bypass;
  logic              pop;
  logic              store;
  logic [ADDR_W-1:0] pop_idx;
  logic              pop_err;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Age counts cycles since acceptance, the acceptance cycle being age 0.
  // With LATENCY=1 an incoming request into an empty queue is already due,
  // so it is answered straight from the bus without occupying a slot.
  always_comb begin
    off      = bus.addr - BASE;
    req_err  = (bus.addr[1:0] != 2'b00) || ((off[31:2] >> ADDR_W) != 30'd0);
    req_idx  = off[ADDR_W+1:2];
    bus.addr_ok = ~rst & (count < 3'(DEPTH));
    push     = bus.req & bus.addr_ok;
    head_rdy = q_vld[head] && (q_age[head] >= LAT_M1);
    bypass   = (LATENCY == 1) && push && (count == 3'd0);
    pop      = head_rdy | bypass;
    store    = push & ~bypass;
    pop_idx  = bypass ? req_idx : q_idx[head];
    pop_err  = bypass ? req_err : q_err[head];
  end

  // Array contents survive reset; the read below sees pre-load data on a
  // same-edge collision.
  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_idx] <= ld_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_vld         <= '0;
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      bus.data_ok   <= 1'b0;
      bus.rdata     <= '0;
      bus.rdata_err <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (q_vld[i] && (q_age[i] < LAT)) q_age[i] <= q_age[i] + 4'd1;
      end
      if (head_rdy) begin
        q_vld[head] <= 1'b0;
        head        <= nxt(head);
      end
      if (store) begin
        q_vld[tail] <= 1'b1;
        q_idx[tail] <= req_idx;
        q_err[tail] <= req_err;
        q_age[tail] <= 4'd1;
        tail        <= nxt(tail);
      end
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      bus.data_ok <= pop;
      if (pop) begin
        bus.rdata     <= pop_err ? 32'd0 : mem[pop_idx];
        bus.rdata_err <= pop_err;
      end
    end
  end

endmodule

// File: doc/inst_sram_responder.md
Name: inst_sram_responder

Overview:
Memory-side responder for the instruction-fetch port. It accepts fetch requests (req/addr) from the fetch stage, holds up to DEPTH outstanding requests in order, and returns 32-bit instruction words after a programmable latency.
A backing word array is preloaded through a simple load port. Misaligned and out-of-window fetches are reported with an error flag. It stands in for the instruction SRAM or bridge in simulation and in FPGA bring-up.

Parameters:
ADDR_W, 12, word-index width; the array holds 2^ADDR_W words.
BASE, 32'h1c000000, byte address of word 0.
DEPTH, 2, maximum outstanding accepted requests; legal range 1..4.
LATENCY, 1, minimum cycles from acceptance to data_ok; legal range 1..8.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req  in  1  fetch request valid
addr  in  32  fetch byte address
addr_ok  out  1  request accepted this cycle when req & addr_ok
data_ok  out  1  one-cycle pulse; rdata/rdata_err valid
rdata  out  32  instruction word
rdata_err  out  1  fetch faulted (misaligned or outside the window); rdata = 0
ld_en  in  1  preload write enable
ld_idx  in  ADDR_W  preload word index
ld_data  in  32  preload data

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high.
- Reset values: count=0, queue empty, data_ok=0, rdata=0, rdata_err=0. addr_ok=0 in any cycle where rst=1. Array contents are not reset.
- addr_ok: combinational, equal to ~rst & (count < DEPTH). It does not depend on a same-cycle pop.
- Acceptance: a request is accepted in cycle t when req & addr_ok are both high in t. On acceptance, the queue entry captures the address, err, and age=0.
- err rule: err = (addr[1:0] != 0) | ((addr - BASE) >> 2 >= 2^ADDR_W). The subtraction is unsigned 32-bit, so addresses below BASE wrap and fault.
- Ageing: every valid entry increments age each cycle, saturating at LATENCY. Entries age in parallel, so pipelined throughput is 1 word per cycle when DEPTH ≥ LATENCY+1.
- Response timing: data_ok, rdata and rdata_err are registered outputs. The head entry is popped at the edge ending cycle c when its age ≥ LATENCY-1 in c, with one pop at most per edge. data_ok is high in cycle c+1.
- Resulting latency: with an idle queue, a request accepted in cycle t gives data_ok in cycle t+LATENCY.
- Ordering: responses come back strictly in acceptance order. A younger entry whose latency has expired waits until the next cycle after the older response.
- Data read: rdata is read from the array at the pop edge, from index (addr-BASE)>>2. If err, rdata=0 and rdata_err=1.
- Counter update: count is updated with push and pop together. A simultaneous push and pop leaves count unchanged. A full queue (count=DEPTH) blocks acceptance even in a pop cycle.
- Load port: ld_en writes the array at the edge. A same-edge pop from the same index returns the old data (read-before-write).
- Reset mid-operation: all pending entries are dropped. No data_ok is produced for requests accepted before rst, and data_ok=0 in the cycle after rst.
- Synthesis check: DEPTH or LATENCY outside the legal range gives a $error at elaboration.

Test Plan:
- Single fetch, LATENCY=1: preload idx0=32'h02800c0c, then req addr=32'h1c000000 in cycle 5 → addr_ok=1 in 5; data_ok=1 in 6 with rdata=32'h02800c0c, rdata_err=0; data_ok=0 in 7.
- Backpressure, DEPTH=2, LATENCY=3: req held high with addrs 1c000000, 1c000004, 1c000008 from cycle 0 → accepted in 0 and 1, addr_ok=0 in 2 (count=2), third accepted in 3; data_ok in 3, 4 and 6, in order.
- Pipelining, DEPTH=4, LATENCY=3: 4 consecutive requests in cycles 0–3 → data_ok in cycles 3, 4, 5, 6 carrying words idx0..3.
- Faults: addr=32'h1c000002 → data_ok with rdata_err=1, rdata=0. addr=32'h1bfffffc (below BASE) → rdata_err=1. addr=BASE+4*2^ADDR_W → rdata_err=1.
- Load collision: pop of idx5 (old 32'hAAAA0000) on the same edge as ld_en idx5=32'h5555FFFF → rdata=32'hAAAA0000; a later fetch of idx5 → 32'h5555FFFF.
- Reset mid-flight, LATENCY=4: accept 2 requests, assert rst for 1 cycle before the first response → no data_ok afterwards; addr_ok=0 during rst and 1 the next cycle; count restarts at 0.
